// File: rtl/csr_pkg.sv
// Shared definitions for the CSR counter unit: address map, CSR op encoding
// and the read-modify-write helper used by every writable CSR.
package csr_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
    localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
    localparam logic [11:0] CSR_USER_BASE     = 12'hC00;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    function automatic logic [31:0] csr_apply_op(input logic [31:0] old,
                                                 input logic [31:0] wdata,
                                                 input csr_op_e     op);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old | wdata;
            CSR_OP_CLEAR: return old & ~wdata;
            default:      return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_W-bit CSR counter. A write to either half wins over the increment
// for the whole counter in that cycle; wrap-around is plain modular addition.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (wr_lo) begin
            value[31:0] <= wdata;
        end else if (wr_hi) begin
            value[CNT_W-1:32] <= wdata[CNT_W-33:0];
        end else if (inc && !inhibit) begin
            value <= value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/csr_counter_unit.sv
// mcycle / minstret / mhpmcounterN block with user read-only shadows and
// mcountinhibit. Reads are combinational; writes commit on the next clock edge.
module csr_counter_unit
    import csr_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int N_HPM = 4,
    parameter int XLEN  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [11:0]                    csr_addr,
    input  logic [1:0]                     csr_op,
    input  logic [XLEN-1:0]                csr_wdata,
    input  logic                           csr_valid,
    input  logic                           inst_retire,
    input  logic [(N_HPM > 0 ? N_HPM : 1)-1:0] hpm_event,
    output logic [XLEN-1:0]                csr_rdata,
    output logic                           csr_hit,
    output logic                           csr_illegal
);

    localparam int NCNT = 2 + N_HPM;
    localparam logic [6:0] OFF_CY  = CSR_MCYCLE[6:0];
    localparam logic [6:0] OFF_IR  = CSR_MINSTRET[6:0];
    localparam logic [6:0] OFF_HPM = CSR_MHPM_BASE[6:0];

    logic [CNT_W-1:0] cnt_val [NCNT];
    logic [NCNT-1:0]  cnt_inc;
    logic [NCNT-1:0]  cnt_wr_lo;
    logic [NCNT-1:0]  cnt_wr_hi;
    logic [NCNT-1:0]  inhibit;
    logic [NCNT-1:0]  inhibit_next;
    logic             inhibit_wr;

    csr_op_e     op;
    logic [11:0] base;
    logic [6:0]  idx;
    logic [4:0]  sel;
    logic        is_mach, is_user, is_hi, cnt_hit, inh_hit;
    logic        eff_write, wr_ok;
    logic [31:0] inh_rd, old_val, new_val;

    assign op = csr_op_e'(csr_op);

    // Counter slot 0 is mcycle, 1 is minstret, 2+i is hpm i; the same slot
    // numbering is used for the internal inhibit vector.
    always_comb begin
        base    = {csr_addr[11:8], 8'h00};
        idx     = csr_addr[6:0];
        is_hi   = (csr_addr & CSR_HI_OFFSET) != '0;
        is_mach = base == CSR_MCYCLE;
        is_user = base == CSR_USER_BASE;
        inh_hit = csr_addr == CSR_MCOUNTINHIBIT;
        cnt_hit = 1'b0;
        sel     = '0;
        if (is_mach || is_user) begin
            if (idx == OFF_CY) begin
                cnt_hit = 1'b1;
                sel     = 5'd0;
            end else if (idx == OFF_IR) begin
                cnt_hit = 1'b1;
                sel     = 5'd1;
            end else if (idx >= OFF_HPM && idx < OFF_HPM + 7'(N_HPM)) begin
                cnt_hit = 1'b1;
                sel     = 5'(idx - OFF_HPM) + 5'd2;
            end
        end
    end

    always_comb begin
        inh_rd    = '0;
        inh_rd[0] = inhibit[0];
        inh_rd[2] = inhibit[1];
        for (int i = 0; i < N_HPM; i++) begin
            inh_rd[3+i] = inhibit[2+i];
        end
        old_val = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (cnt_hit && sel == 5'(k)) begin
                old_val = is_hi ? 32'(cnt_val[k][CNT_W-1:32]) : cnt_val[k][31:0];
            end
        end
        if (inh_hit) begin
            old_val = inh_rd;
        end
    end

    // Set/clear with a zero mask is a pure read and therefore never illegal.
    always_comb begin
        new_val     = csr_apply_op(old_val, csr_wdata, op);
        eff_write   = csr_valid && (op != CSR_OP_NONE) &&
                      (op == CSR_OP_WRITE || csr_wdata != '0);
        csr_hit     = cnt_hit || inh_hit;
        csr_rdata   = old_val;
        csr_illegal = cnt_hit && is_user && eff_write;
        wr_ok       = eff_write && csr_hit && !is_user;
        inhibit_wr  = wr_ok && inh_hit;
        inhibit_next    = '0;
        inhibit_next[0] = new_val[0];
        inhibit_next[1] = new_val[2];
        for (int i = 0; i < N_HPM; i++) begin
            inhibit_next[2+i] = new_val[3+i];
        end
        cnt_wr_lo = '0;
        cnt_wr_hi = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (wr_ok && cnt_hit && sel == 5'(k)) begin
                cnt_wr_lo[k] = !is_hi;
                cnt_wr_hi[k] = is_hi;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit <= '0;
        end else if (inhibit_wr) begin
            inhibit <= inhibit_next;
        end
    end

    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = inst_retire;

    if (N_HPM > 0) begin : g_ev
        assign cnt_inc[NCNT-1:2] = hpm_event;
    end else begin : g_noev
        logic unused_ev;
        assign unused_ev = hpm_event[0];
    end

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        csr_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (cnt_inc[k]),
            .inhibit (inhibit[k]),
            .wr_lo   (cnt_wr_lo[k]),
            .wr_hi   (cnt_wr_hi[k]),
            .wdata   (new_val),
            .value   (cnt_val[k])
        );
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Scoreboard bench for csr_counter_unit: a default instance (64-bit, 4 hpm)
// and a reduced instance (40-bit, no hpm) share the CSR input bus.
module tb_csr_counter_unit;

    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_W  = 2'd1;
    localparam logic [1:0] OP_S  = 2'd2;
    localparam logic [1:0] OP_C  = 2'd3;

    typedef struct packed {
        logic        dut_b;
        logic [31:0] rdata;
        logic        hit;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_b = 1'b1;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_valid = 1'b0;
    logic        inst_retire = 1'b0;
    logic [3:0]  hpm_event = '0;
    logic [0:0]  hpm_event_b = '0;
    logic [31:0] rdata_a, rdata_b;
    logic        hit_a, hit_b, ill_a, ill_b;

    exp_t  exp_q[$];
    string name_q[$];
    logic  obs_valid = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    csr_counter_unit #(.CNT_W(64), .N_HPM(4), .XLEN(32)) dut_a (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_valid(csr_valid), .inst_retire(inst_retire),
        .hpm_event(hpm_event), .csr_rdata(rdata_a), .csr_hit(hit_a),
        .csr_illegal(ill_a)
    );

    csr_counter_unit #(.CNT_W(40), .N_HPM(0), .XLEN(32)) dut_b (
        .clk(clk), .rst(rst_b), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_valid(csr_valid), .inst_retire(inst_retire),
        .hpm_event(hpm_event_b), .csr_rdata(rdata_b), .csr_hit(hit_b),
        .csr_illegal(ill_b)
    );

    task automatic checkOutput(input exp_t e, input string name);
        logic [31:0] r;
        logic        h;
        logic        il;
        r  = e.dut_b ? rdata_b : rdata_a;
        h  = e.dut_b ? hit_b : hit_a;
        il = e.dut_b ? ill_b : ill_a;
        vectors++;
        if ({r, h, il} !== {e.rdata, e.hit, e.illegal}) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdata=%h hit=%b illegal=%b, want rdata=%h hit=%b illegal=%b",
                     name, r, h, il, e.rdata, e.hit, e.illegal);
        end
    endtask

    // Outputs are combinational, so the monitor samples mid-cycle.
    always @(negedge clk) begin
        if (obs_valid) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL monitor: got an observation, want a queued expectation");
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(e, n);
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op,
                                 input logic [31:0] wdata, input logic valid,
                                 input logic retire, input logic [3:0] ev,
                                 input logic chk, input logic on_b,
                                 input logic [31:0] exp_rdata, input logic exp_hit,
                                 input logic exp_ill, input string name);
        @(posedge clk);
        #1;
        csr_addr    = addr;
        csr_op      = op;
        csr_wdata   = wdata;
        csr_valid   = valid;
        inst_retire = retire;
        hpm_event   = ev;
        obs_valid   = chk;
        if (chk) begin
            exp_q.push_back('{on_b, exp_rdata, exp_hit, exp_ill});
            name_q.push_back(name);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(12'h000, OP_RD, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, want finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state, then ten free-running cycles.
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "reset_mcycle");
        rst = 1'b0;
        applyStimulus(12'h320, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "reset_inhibit");
        idle(8);
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd10, 1, 0, "mcycle_10");
        applyStimulus(12'hB02, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "minstret_0");
        applyStimulus(12'hC80, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "cycleh_0");
        applyStimulus(12'hB01, OP_W, 32'h5, 1, 0, 4'h0, 1, 0, 32'd0, 0, 0, "unmapped_b01");

        // Full-width wrap with carry from lo into hi.
        applyStimulus(12'hB00, OP_W, 32'hFFFF_FFFF, 1, 0, 4'h0, 1, 0, 32'd14, 1, 0, "wr_cycle_lo");
        applyStimulus(12'hB80, OP_W, 32'hFFFF_FFFF, 1, 0, 4'h0, 1, 0, 32'd0, 1, 0, "wr_cycle_hi");
        applyStimulus(12'hB80, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'hFFFF_FFFF, 1, 0, "cycle_all_ones");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "wrap_lo");
        applyStimulus(12'hB80, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 1, 0, "wrap_hi");

        // Inhibit CY and IR, then release.
        applyStimulus(12'h320, OP_S, 32'h5, 1, 0, 4'h0, 1, 0, 32'd0, 1, 0, "set_inhibit");
        applyStimulus(12'h320, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'h5, 1, 0, "inhibit_rd");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 1, 4'h0, 1, 0, 32'd3, 1, 0, "cy_frozen");
        applyStimulus(12'hB02, OP_RD, 32'h0, 0, 1, 4'h0, 1, 0, 32'd0, 1, 0, "ir_frozen");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 1, 4'h0, 1, 0, 32'd3, 1, 0, "cy_frozen2");
        applyStimulus(12'h320, OP_C, 32'h5, 1, 0, 4'h0, 1, 0, 32'h5, 1, 0, "clr_inhibit");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd3, 1, 0, "cy_clr_edge");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 1, 4'h0, 1, 0, 32'd4, 1, 0, "cy_resume");
        applyStimulus(12'hB02, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd1, 1, 0, "ir_resume");

        // hpm1 counting with a write landing in the 4th event cycle.
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd0, 1, 0, "hpm1_0");
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd1, 1, 0, "hpm1_1");
        applyStimulus(12'hC04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd2, 1, 0, "hpm1_shadow");
        applyStimulus(12'hB04, OP_W, 32'd100, 1, 0, 4'h2, 1, 0, 32'd3, 1, 0, "hpm1_wr");
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd100, 1, 0, "hpm1_wr_noinc");
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd101, 1, 0, "hpm1_101");
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h2, 1, 0, 32'd102, 1, 0, "hpm1_102");
        applyStimulus(12'hB04, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd103, 1, 0, "hpm1_final");
        applyStimulus(12'hB07, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd0, 0, 0, "unmapped_hpm4");

        // Hardwired mcountinhibit bits.
        applyStimulus(12'h320, OP_W, 32'hFFFF_FFFF, 1, 0, 4'h0, 1, 0, 32'd0, 1, 0, "inhibit_all");
        applyStimulus(12'h320, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'h7D, 1, 0, "inhibit_mask");
        applyStimulus(12'h320, OP_W, 32'h0, 1, 0, 4'h0, 1, 0, 32'h7D, 1, 0, "inhibit_none");

        // Writes to the user shadows.
        applyStimulus(12'hC00, OP_W, 32'd123, 1, 0, 4'h0, 1, 0, 32'd16, 1, 1, "illegal_wr");
        applyStimulus(12'hC00, OP_S, 32'h0, 1, 0, 4'h0, 1, 0, 32'd17, 1, 0, "csrrs_x0_user");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 0, 32'd18, 1, 0, "cy_after_illegal");
        applyStimulus(12'hC02, OP_C, 32'h1, 1, 0, 4'h0, 1, 0, 32'd1, 1, 1, "illegal_clr");
        applyStimulus(12'hC00, OP_W, 32'h5, 0, 0, 4'h0, 1, 0, 32'd20, 1, 0, "user_not_valid");

        // Reduced instance: no hpm counters, 40-bit width.
        applyStimulus(12'hB03, OP_RD, 32'h0, 0, 0, 4'h0, 1, 1, 32'd0, 0, 0, "b_no_hpm");
        rst_b = 1'b0;
        applyStimulus(12'hB80, OP_W, 32'hFFFF_FFFF, 1, 0, 4'h0, 1, 1, 32'd0, 1, 0, "b_wr_hi");
        applyStimulus(12'hB80, OP_RD, 32'h0, 0, 0, 4'h0, 1, 1, 32'h0000_00FF, 1, 0, "b_hi_trunc");
        applyStimulus(12'hB00, OP_RD, 32'h0, 0, 0, 4'h0, 1, 1, 32'd2, 1, 0, "b_lo");
        applyStimulus(12'h320, OP_W, 32'hFFFF_FFFF, 1, 0, 4'h0, 1, 1, 32'd0, 1, 0, "b_inhibit_wr");
        applyStimulus(12'h320, OP_RD, 32'h0, 0, 0, 4'h0, 1, 1, 32'h5, 1, 0, "b_inhibit_mask");

        idle(2);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
